// File: rtl/capture_compare_channel.sv
// Timer capture/compare channel: output compare with PWM modes and preloadable CCR,
// or input capture of the time-base count. Define CC_INPUT_FILTER_EN to add the input filter.
module capture_compare_channel #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 uev_i,
  input  logic                 cc_sel_i,
  input  logic [2:0]           ocm_i,
  input  logic                 ocpe_i,
  input  logic                 ccp_i,
  input  logic                 cce_i,
  input  logic [CNT_WIDTH-1:0] ccr_i,
  input  logic                 ccr_we_i,
  input  logic                 ic_i,
  input  logic [3:0]           icf_i,
  input  logic                 ccif_clr_i,
  input  logic                 ccof_clr_i,
  output logic                 oc_o,
  output logic [CNT_WIDTH-1:0] ccr_o,
  output logic                 ccif_o,
  output logic                 ccof_o
);

  localparam logic [2:0] OCM_HOLD  = 3'b000;
  localparam logic [2:0] OCM_SET   = 3'b001;
  localparam logic [2:0] OCM_CLR   = 3'b010;
  localparam logic [2:0] OCM_TGL   = 3'b011;
  localparam logic [2:0] OCM_LO    = 3'b100;
  localparam logic [2:0] OCM_HI    = 3'b101;
  localparam logic [2:0] OCM_PWM1  = 3'b110;
  localparam logic [2:0] OCM_PWM2  = 3'b111;

  logic [CNT_WIDTH-1:0] ccr_act, ccr_pre;
  logic                 oc_ref, oc_ref_nxt, oc_q;
  logic                 ccif_q, ccof_q;
  logic [1:0]           ic_sync;
  logic                 ic_filt, ic_prev;
  logic                 edge_det, cap_evt;
  logic                 match, below, cmp_evt;

  // ---------------- capture input path ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ic_sync <= 2'b00;
      ic_prev <= 1'b0;
    end else begin
      ic_sync <= {ic_sync[0], ic_i};
      ic_prev <= ic_filt;
    end
  end

`ifdef CC_INPUT_FILTER_EN
  logic       ic_filt_q;
  logic [3:0] flt_cnt;

  // Output flips only after icf_i consecutive disagreeing samples; any agreeing sample restarts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ic_filt_q <= 1'b0;
      flt_cnt   <= 4'd0;
    end else if (icf_i == 4'd0) begin
      ic_filt_q <= ic_sync[1];
      flt_cnt   <= 4'd0;
    end else if (ic_sync[1] != ic_filt_q) begin
      if (flt_cnt == icf_i - 4'd1) begin
        ic_filt_q <= ic_sync[1];
        flt_cnt   <= 4'd0;
      end else begin
        flt_cnt <= flt_cnt + 4'd1;
      end
    end else begin
      flt_cnt <= 4'd0;
    end
  end

  assign ic_filt = (icf_i == 4'd0) ? ic_sync[1] : ic_filt_q;
`else
  logic unused_icf;
  assign unused_icf = ^icf_i;
  assign ic_filt    = ic_sync[1];
`endif

  assign edge_det = ccp_i ? (~ic_filt & ic_prev) : (ic_filt & ~ic_prev);
  assign cap_evt  = cc_sel_i & cce_i & edge_det;

  // ---------------- compare path ----------------
  assign match   = (cnt_i == ccr_act);
  assign below   = (cnt_i <  ccr_act);
  assign cmp_evt = ~cc_sel_i & cce_i & match;

  // oc_ref is frozen while the channel is in capture mode.
  always_comb begin
    oc_ref_nxt = oc_ref;
    if (!cc_sel_i) begin
      case (ocm_i)
        OCM_HOLD: oc_ref_nxt = oc_ref;
        OCM_SET:  oc_ref_nxt = match ? 1'b1 : oc_ref;
        OCM_CLR:  oc_ref_nxt = match ? 1'b0 : oc_ref;
        OCM_TGL:  oc_ref_nxt = match ? ~oc_ref : oc_ref;
        OCM_LO:   oc_ref_nxt = 1'b0;
        OCM_HI:   oc_ref_nxt = 1'b1;
        OCM_PWM1: oc_ref_nxt = below;
        OCM_PWM2: oc_ref_nxt = ~below;
        default:  oc_ref_nxt = oc_ref;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oc_ref <= 1'b0;
      oc_q   <= 1'b0;
    end else begin
      oc_ref <= oc_ref_nxt;
      oc_q   <= (~cc_sel_i & cce_i) ? (oc_ref_nxt ^ ccp_i) : 1'b0;
    end
  end

  // ---------------- CCR ----------------
  // A write coinciding with an update event lands in both registers at once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ccr_act <= '0;
      ccr_pre <= '0;
    end else if (cap_evt) begin
      ccr_act <= cnt_i;
    end else if (!cc_sel_i) begin
      if (ccr_we_i)
        ccr_pre <= ccr_i;
      if (ccr_we_i && (!ocpe_i || uev_i))
        ccr_act <= ccr_i;
      else if (ocpe_i && uev_i)
        ccr_act <= ccr_pre;
    end
  end

  // ---------------- flags (set wins over clear) ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ccif_q <= 1'b0;
      ccof_q <= 1'b0;
    end else begin
      if (cmp_evt || cap_evt) ccif_q <= 1'b1;
      else if (ccif_clr_i)    ccif_q <= 1'b0;
      if (cap_evt && ccif_q)  ccof_q <= 1'b1;
      else if (ccof_clr_i)    ccof_q <= 1'b0;
    end
  end

  assign oc_o   = oc_q;
  assign ccr_o  = ccr_act;
  assign ccif_o = ccif_q;
  assign ccof_o = ccof_q;

endmodule

// File: tb/tb_capture_compare_channel.sv
// Directed bench for capture_compare_channel; expectations go into a scoreboard
// queue tagged with the cycle they apply to, and a negedge monitor compares them.
module tb_capture_compare_channel;

`ifdef CC_INPUT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] cnt_i = '0;
  logic        uev_i = 1'b0;
  logic        cc_sel_i = 1'b0;
  logic [2:0]  ocm_i = '0;
  logic        ocpe_i = 1'b0;
  logic        ccp_i = 1'b0;
  logic        cce_i = 1'b0;
  logic [31:0] ccr_i = '0;
  logic        ccr_we_i = 1'b0;
  logic        ic_i = 1'b0;
  logic [3:0]  icf_i = '0;
  logic        ccif_clr_i = 1'b0;
  logic        ccof_clr_i = 1'b0;
  logic        oc_o, ccif_o, ccof_o;
  logic [31:0] ccr_o;

  capture_compare_channel #(.CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .cnt_i(cnt_i), .uev_i(uev_i), .cc_sel_i(cc_sel_i),
    .ocm_i(ocm_i), .ocpe_i(ocpe_i), .ccp_i(ccp_i), .cce_i(cce_i), .ccr_i(ccr_i),
    .ccr_we_i(ccr_we_i), .ic_i(ic_i), .icf_i(icf_i), .ccif_clr_i(ccif_clr_i),
    .ccof_clr_i(ccof_clr_i), .oc_o(oc_o), .ccr_o(ccr_o), .ccif_o(ccif_o), .ccof_o(ccof_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     cyc;
    string  nm;
    int     oc, cif, cof;   // -1 = don't care
    longint ccr;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s.%s cyc=%0d got=%0h exp=%0h", nm, fld, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.oc  >= 0) chk(e.nm, "oc",   longint'(oc_o),   longint'(e.oc));
      if (e.cif >= 0) chk(e.nm, "ccif", longint'(ccif_o), longint'(e.cif));
      if (e.cof >= 0) chk(e.nm, "ccof", longint'(ccof_o), longint'(e.cof));
      if (e.ccr >= 0) chk(e.nm, "ccr",  longint'(ccr_o),  e.ccr);
    end
  end

  // Expected outputs right after the next rising edge.
  task automatic E(input string nm, input int oc, input int cif, input int cof, input longint ccr);
    exp_t e;
    e.cyc = cyc + 1; e.nm = nm; e.oc = oc; e.cif = cif; e.cof = cof; e.ccr = ccr;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst_i = 1'b0; ccr_we_i = 1'b0; uev_i = 1'b0; ccif_clr_i = 1'b0; ccof_clr_i = 1'b0;
  endtask

  initial begin
    int ccif_m, c, hi, ecif, ecof;
    longint eccr;

    // reset overrides a simultaneous write and force-high
    rst_i = 1; ccr_we_i = 1; ccr_i = 7; cce_i = 1; ocm_i = 3'b101;
    E("reset", 0, 0, 0, 0); step();

    // PWM1, CCR=5, cnt 0..9 twice
    ocm_i = 3'b110; ccp_i = 0; ocpe_i = 0; cc_sel_i = 0;
    cnt_i = 9; ccr_we_i = 1; ccr_i = 5; E("ccr_load", -1, 0, 0, 5); step();
    ccif_m = 0;
    for (int i = 0; i < 20; i++) begin
      c = i % 10; cnt_i = c;
      if (c == 5) ccif_m = 1;
      E("pwm1", (c < 5) ? 1 : 0, ccif_m, 0, 5); step();
    end
    ccp_i = 1; cnt_i = 3; E("pwm1_inv_lo", 0, 1, 0, 5); step();
    cnt_i = 7;            E("pwm1_inv_hi", 1, 1, 0, 5); step();
    ccp_i = 0; cce_i = 0; cnt_i = 2; E("cce_off", 0, -1, 0, 5); step();
    cce_i = 1;

    // PWM1 boundaries: CCR=0 and CCR above every count
    ccr_we_i = 1; ccr_i = 0; cnt_i = 2;   E("ccr0_load", 1, 1, 0, 0); step();
    cnt_i = 0;                            E("pwm_ccr0_a", 0, 1, 0, 0); step();
    cnt_i = 3;                            E("pwm_ccr0_b", 0, 1, 0, 0); step();
    ccr_we_i = 1; ccr_i = 32'hFFFF_FFFF;  E("ccrmax_load", 0, 1, 0, 32'hFFFF_FFFF); step();
    cnt_i = 0;                            E("pwm_max_a", 1, 1, 0, 32'hFFFF_FFFF); step();
    cnt_i = 32'hFFFF_FFFE;                E("pwm_max_b", 1, 1, 0, 32'hFFFF_FFFF); step();
    ccif_clr_i = 1; cnt_i = 5;            E("ccif_clr", 1, 0, 0, 32'hFFFF_FFFF); step();

    // preload: simultaneous we+uev hits both, plain we hits preload only
    ocpe_i = 1; ccr_we_i = 1; ccr_i = 5; uev_i = 1; cnt_i = 0; E("pre_we_uev", -1, 0, 0, 5); step();
    cnt_i = 2; ccr_we_i = 1; ccr_i = 8;  E("pre_we_only", -1, 0, 0, 5); step();
    cnt_i = 5;                           E("pre_match_old", -1, 1, 0, 5); step();
    ccif_clr_i = 1; cnt_i = 6;           E("pre_clr", -1, 0, 0, 5); step();
    cnt_i = 8;                           E("pre_nomatch8", -1, 0, 0, 5); step();
    uev_i = 1; cnt_i = 9;                E("pre_uev", -1, 0, 0, 8); step();
    cnt_i = 8;                           E("pre_match_new", -1, 1, 0, 8); step();
    ocpe_i = 0;

    // forced levels, toggle, clear-vs-set, mid-run reset
    ocm_i = 3'b101; cnt_i = 0; E("force1", 1, -1, 0, 8); step();
    ocm_i = 3'b100;            E("force0", 0, -1, 0, 8); step();
    ocm_i = 3'b011; ccr_we_i = 1; ccr_i = 3; E("tgl_load", 0, -1, 0, 3); step();
    cnt_i = 3; E("tgl_1", 1, 1, 0, 3); step();
    cnt_i = 4; E("tgl_hold", 1, 1, 0, 3); step();
    cnt_i = 3; E("tgl_2", 0, 1, 0, 3); step();
    cnt_i = 3; E("tgl_3", 1, 1, 0, 3); step();
    ccif_clr_i = 1; cnt_i = 3; E("clr_vs_set", 0, 1, 0, 3); step();
    ccif_clr_i = 1; cnt_i = 4; E("clr_only", 0, 0, 0, 3); step();
    cnt_i = 3; E("tgl_4", 1, 1, 0, 3); step();
    rst_i = 1; ccr_we_i = 1; ccr_i = 9; cnt_i = 3; E("rst_mid", 0, 0, 0, 0); step();
    ocm_i = 3'b001; cnt_i = 0; E("set_match", 1, 1, 0, 0); step();
    ocm_i = 3'b010; cnt_i = 1; E("clr_nomatch", 1, 1, 0, 0); step();
    cnt_i = 0;                 E("clr_match", 0, 1, 0, 0); step();
    ocm_i = 3'b111;            E("pwm2_ccr0", 1, 1, 0, 0); step();

    // capture: rising edges, overcapture, writes ignored
    rst_i = 1; E("rst_cap", 0, 0, 0, 0); step();
    cc_sel_i = 1; ccp_i = 0; cce_i = 1; ic_i = 0; ocm_i = 3'b101; ocpe_i = 1;
    for (int j = 0; j < 3; j++) begin
      cnt_i = 50 + j; ccr_we_i = 1; ccr_i = 55; uev_i = 1;
      E("cap_ignore_we", 0, 0, 0, 0); step();
    end
    ocpe_i = 0;
    for (int k = 0; k < 10; k++) begin
      cnt_i = 100 + k;
      ic_i  = (k < 3 || k >= 6);
      eccr  = (k < 2) ? 0 : (k < 8) ? 102 : 108;
      E("cap_rise", 0, (k >= 2) ? 1 : 0, (k >= 8) ? 1 : 0, eccr); step();
    end
    ccif_clr_i = 1; ccof_clr_i = 1; cnt_i = 110; E("cap_clr", 0, 0, 0, 108); step();
    ccp_i = 1; ic_i = 0;
    cnt_i = 200; E("cap_fall_a", 0, 0, 0, 108); step();
    cnt_i = 201; E("cap_fall_b", 0, 0, 0, 108); step();
    cnt_i = 202; E("cap_fall", 0, 1, 0, 202); step();
    cc_sel_i = 0; ccp_i = 0; ocm_i = 3'b000; cnt_i = 0; E("sel_back", 0, 1, 0, 202); step();

    // input filter (icf=4): 3-cycle glitch then 6-cycle pulse
    rst_i = 1; E("rst_flt", 0, 0, 0, 0); step();
    cc_sel_i = 1; ccp_i = 0; cce_i = 1; icf_i = 4; ic_i = 0;
    for (int j = 0; j < 3; j++) begin cnt_i = 290 + j; step(); end
    for (int k = 0; k < 25; k++) begin
      cnt_i = 300 + k;
      hi = (k < 3 || (k >= 10 && k < 16));
      ic_i = hi[0];
      ccif_clr_i = (k == 10);
      if (FILT) begin
        eccr = (k >= 16) ? 316 : 0;
        ecif = (k >= 16) ? 1 : 0;
      end else begin
        eccr = (k < 2) ? 0 : (k < 12) ? 302 : 312;
        ecif = ((k >= 2 && k < 10) || k >= 12) ? 1 : 0;
      end
      ecof = 0;
      E("filter", 0, ecif, ecof, eccr); step();
    end

    repeat (3) step();
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/capture_compare_channel.md
CAPTURE_COMPARE_CHANNEL -- requirements
Module: capture_compare_channel

Interface
REQ-001 SHALL have parameter: CNT_WIDTH, 32, width of counter and CCR.
REQ-002 SHALL have port: clk_i  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: cnt_i  input  CNT_WIDTH  counter value from time base unit.
REQ-005 SHALL have port: uev_i  input  1  update event pulse from time base unit.
REQ-006 SHALL have port: cc_sel_i  input  1  0 = output compare, 1 = input capture.
REQ-007 SHALL have port: ocm_i  input  3  output compare mode.
REQ-008 SHALL have port: ocpe_i  input  1  CCR preload enable.
REQ-009 SHALL have port: ccp_i  input  1  output polarity invert (compare) / falling-edge select (capture).
REQ-010 SHALL have port: cce_i  input  1  channel enable.
REQ-011 SHALL have ports: ccr_i  input  CNT_WIDTH  CCR write data; ccr_we_i  input  1  CCR write strobe.
REQ-012 SHALL have ports: ic_i  input  1  asynchronous capture input; icf_i  input  4  filter length.
REQ-013 SHALL have ports: ccif_clr_i and ccof_clr_i, each input  1  flag clear strobe.
REQ-014 SHALL have ports: oc_o  output  1  compare output; ccr_o  output  CNT_WIDTH  active CCR.
REQ-015 SHALL have ports: ccif_o  output  1  capture/compare flag; ccof_o  output  1  overcapture flag.

Function
REQ-016 SHALL define match as cnt_i == active CCR, evaluated combinationally each cycle.
REQ-017 Compare mode, ocpe_i=0: ccr_we_i SHALL load ccr_i into the active CCR at the same edge.
REQ-018 Compare mode, ocpe_i=1: ccr_we_i SHALL load the preload register only; uev_i SHALL copy preload to active CCR; on simultaneous we and uev, ccr_i SHALL reach both registers.
REQ-019 SHALL keep a registered oc_ref updated per ocm_i: 000 hold; 001 set on match; 010 clear on match; 011 toggle on match; 100 force 0; 101 force 1; 110 PWM1 (1 while cnt_i < CCR, else 0); 111 PWM2 (inverse of PWM1).
REQ-020 SHALL drive oc_o registered as cce_i ? (next oc_ref XOR ccp_i) : 0, i.e. one-cycle latency from cnt_i.
REQ-021 PWM1 with CCR=0 SHALL hold oc_ref at 0; CCR greater than every cnt_i value SHALL hold it at 1.
REQ-022 Compare mode SHALL set ccif_o at the edge where match and cce_i are true, in every ocm_i.
REQ-023 Capture mode SHALL pass ic_i through a 2-flop synchronizer, then the filter, then an edge detector selecting rising (ccp_i=0) or falling (ccp_i=1).
REQ-024 A detected edge with cce_i=1 SHALL load the current cnt_i into active CCR and set ccif_o at the same edge; unfiltered, this is the 2nd edge after ic_i is first sampled.
REQ-025 A capture while ccif_o=1 SHALL also set ccof_o.
REQ-026 Capture mode SHALL ignore ccr_we_i, ocpe_i and uev_i for CCR.
REQ-027 Simultaneous set and clear of a flag SHALL leave the flag set.
REQ-028 Changing cc_sel_i SHALL NOT alter CCR, flags or oc_ref; oc_o SHALL be 0 in capture mode.
REQ-029 ccr_o SHALL always show the active CCR.

Reset
REQ-030 rst_i SHALL clear active CCR, preload, oc_ref, oc_o, ccif_o, ccof_o, synchronizer, edge history and filter counter to 0 at the next edge, aborting any pending capture or filtering.
REQ-031 rst_i SHALL override every other input in the same cycle.

Configuration
REQ-032 With CC_INPUT_FILTER_EN defined, the filter output SHALL change only after the synchronized input differs from it for icf_i consecutive cycles (icf_i=0 bypass), with the mismatch counter restarting on any agreeing sample.
REQ-033 Without CC_INPUT_FILTER_EN, the filter SHALL be absent, icf_i ignored, synchronizer output fed directly to the edge detector.

Verification
REQ-034 ocm=110, ccp=0, cce=1, ccr=5, cnt 0..9 repeating -> oc_o=1 for cnt 0..4, 0 for 5..9, one cycle late; ccif pulses-set on cnt=5.
REQ-035 ocpe=1, ccr=5 active, write ccr=8 at cnt=2 -> match still at 5; after uev_i, ccr_o=8 and match at 8.
REQ-036 cc_sel=1, ccp=0, rising ic_i sampled at cycle with cnt=100, counting +1 -> ccr_o=102, ccif_o=1; second rising edge before clear -> ccof_o=1.
REQ-037 CC_INPUT_FILTER_EN, icf=4: 3-cycle high glitch -> no capture; 6-cycle high pulse -> one capture 4 cycles later than unfiltered.
REQ-038 ocm=011 toggling mid-run, rst_i asserted for one cycle -> all outputs 0 next edge; ccif_clr_i with simultaneous match -> ccif_o stays 1.
